// File: rtl/score_pkg.sv
// Shared types and width helpers for the score accumulator.
//   mode_e     : scoring mode carried on REG_SetupMAPA
//   state_e    : accumulator FSM states
//   bonus_width: width of the registered bonus (LEVEL_W + ROUND_W + 1)
//   max_u      : unsigned maximum, used for the pre-saturation sum width
package score_pkg;

   typedef enum logic [1:0] {
      MODE_PLAIN  = 2'd0,
      MODE_STREAK = 2'd1,
      MODE_DOUBLE = 2'd2,
      MODE_LEVEL  = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      ACC  = 2'd2
   } state_e;

   function automatic int unsigned bonus_width(input int unsigned level_w,
                                               input int unsigned round_w);
      return level_w + round_w + 1;
   endfunction

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/score_bonus_calc.sv
// Combinational bonus for one completed round.
//   i_level   : captured game level
//   i_round   : captured sequence length
//   i_mode    : captured scoring mode
//   i_streak  : captured streak of the addressed channel
//   o_bonus_c : bonus, BONUS_W bits (never overflows for any input)
module score_bonus_calc
   import score_pkg::*;
#(
   parameter  int unsigned LEVEL_W = 2,
   parameter  int unsigned ROUND_W = 4,
   localparam int unsigned BONUS_W = bonus_width(LEVEL_W, ROUND_W)
) (
   input  logic [LEVEL_W-1:0] i_level,
   input  logic [ROUND_W-1:0] i_round,
   input  mode_e              i_mode,
   input  logic [ROUND_W-1:0] i_streak,
   output logic [BONUS_W-1:0] o_bonus_c
);

   localparam int unsigned P_W = LEVEL_W + ROUND_W;

   logic [P_W-1:0] w_prod;

   assign w_prod = P_W'(i_level) * P_W'(i_round);

   // Mode select; the widest case (2*P) fits exactly in BONUS_W.
   always_comb begin
      o_bonus_c = '0;
      case (i_mode)
         MODE_PLAIN:  o_bonus_c = BONUS_W'(w_prod);
         MODE_STREAK: o_bonus_c = BONUS_W'(w_prod) + BONUS_W'(i_streak);
         MODE_DOUBLE: o_bonus_c = {w_prod, 1'b0};
         MODE_LEVEL:  o_bonus_c = BONUS_W'(w_prod) + BONUS_W'(i_level);
         default:     o_bonus_c = '0;
      endcase
   end

endmodule

// File: rtl/score_accum.sv
// Multi-channel score accumulator: IDLE -> CALC -> ACC per accepted round.
//   CLOCK, RESET     : clock, async active-low reset
//   ROUND_OK/MISS    : round completed / failed pulses for channel PLAYER
//   ROUND, REG_Setup*: round length, level and scoring mode captured on accept
//   PLAYER           : addressed channel, also selects POINTS
//   CLEAR            : zero totals/streaks/SAT, abort in-flight op
//   POINTS           : combinational read of total[PLAYER]
//   HIGH_SCORE       : best total since reset
//   SCORE_VALID, DROP: one-cycle pulses; BUSY: op in flight; SAT: sticky clip
module score_accum
   import score_pkg::*;
#(
   parameter  int unsigned LEVEL_W   = 2,
   parameter  int unsigned ROUND_W   = 4,
   parameter  int unsigned POINTS_W  = 8,
   parameter  int unsigned N_PLAYERS = 2,
   localparam int unsigned PLAYER_W  = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1
) (
   input  logic                CLOCK,
   input  logic                RESET,
   input  logic                ROUND_OK,
   input  logic                ROUND_MISS,
   input  logic [ROUND_W-1:0]  ROUND,
   input  logic [LEVEL_W-1:0]  REG_SetupLEVEL,
   input  logic [1:0]          REG_SetupMAPA,
   input  logic [PLAYER_W-1:0] PLAYER,
   input  logic                CLEAR,
   output logic [POINTS_W-1:0] POINTS,
   output logic [POINTS_W-1:0] HIGH_SCORE,
   output logic                SCORE_VALID,
   output logic                BUSY,
   output logic                DROP,
   output logic                SAT
);

   localparam int unsigned BONUS_W = bonus_width(LEVEL_W, ROUND_W);
   localparam int unsigned SUM_W   = max_u(BONUS_W, POINTS_W) + 1;

   state_e              r_state;
   state_e              w_state_nxt;
   logic                w_accept;
   logic                w_acc;
   logic                w_drop_nxt;
   logic                w_player_ok;

   logic [LEVEL_W-1:0]  r_level;
   logic [ROUND_W-1:0]  r_round;
   mode_e               r_mode;
   logic [PLAYER_W-1:0] r_player;
   logic [ROUND_W-1:0]  r_streak_cap;
   logic [BONUS_W-1:0]  r_bonus;
   logic [BONUS_W-1:0]  w_bonus_c;

   logic [POINTS_W-1:0] r_total      [N_PLAYERS];
   logic [POINTS_W-1:0] w_total_nxt  [N_PLAYERS];
   logic [ROUND_W-1:0]  r_streak     [N_PLAYERS];
   logic [ROUND_W-1:0]  w_streak_nxt [N_PLAYERS];

   logic [POINTS_W-1:0] r_high;
   logic                r_valid;
   logic                r_drop;
   logic                r_sat;

   logic [ROUND_W-1:0]  w_cap_streak;
   logic [SUM_W-1:0]    w_sum;
   logic                w_clip;
   logic [POINTS_W-1:0] w_total_new;

   assign w_player_ok = 32'(PLAYER) < N_PLAYERS;

   // FSM state register
   always_ff @(posedge CLOCK or negedge RESET) begin : p_state
      if (!RESET) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // FSM next state and control strobes; CLEAR wins silently
   always_comb begin : p_fsm
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_acc       = 1'b0;
      w_drop_nxt  = 1'b0;
      if (CLEAR) begin
         w_state_nxt = IDLE;
      end else begin
         case (r_state)
            IDLE: begin
               if (ROUND_OK) begin
                  if (w_player_ok) begin
                     w_accept    = 1'b1;
                     w_state_nxt = CALC;
                  end else begin
                     w_drop_nxt = 1'b1;
                  end
               end
            end
            CALC: begin
               w_drop_nxt  = ROUND_OK;
               w_state_nxt = ACC;
            end
            ACC: begin
               w_drop_nxt  = ROUND_OK;
               w_acc       = 1'b1;
               w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   score_bonus_calc #(
      .LEVEL_W (LEVEL_W),
      .ROUND_W (ROUND_W)
   ) u_bonus (
      .i_level   (r_level),
      .i_round   (r_round),
      .i_mode    (r_mode),
      .i_streak  (r_streak_cap),
      .o_bonus_c (w_bonus_c)
   );

   // A same-cycle miss on the accepted channel is seen before capture
   assign w_cap_streak = ROUND_MISS ? '0 : r_streak[PLAYER];

   // Saturating add; clipped when anything lands above the POINTS_W bits
   assign w_sum       = SUM_W'(r_total[r_player]) + SUM_W'(r_bonus);
   assign w_clip      = |w_sum[SUM_W-1:POINTS_W];
   assign w_total_new = w_clip ? '1 : w_sum[POINTS_W-1:0];

   // Per-channel next totals/streaks: miss zeroes first, ACC increment after
   for (genvar g = 0; g < N_PLAYERS; g++) begin : g_chan
      logic                w_hit_acc;
      logic                w_hit_miss;
      logic [ROUND_W-1:0]  w_base;

      assign w_hit_acc  = w_acc && (r_player == PLAYER_W'(g));
      assign w_hit_miss = ROUND_MISS && (PLAYER == PLAYER_W'(g));
      assign w_base     = w_hit_miss ? '0 : r_streak[g];

      assign w_streak_nxt[g] = CLEAR ? '0 :
                               (w_hit_acc && (w_base != '1)) ? w_base + 1'b1 : w_base;
      assign w_total_nxt[g]  = CLEAR ? '0 : (w_hit_acc ? w_total_new : r_total[g]);
   end

   // Datapath registers
   always_ff @(posedge CLOCK or negedge RESET) begin : p_data
      if (!RESET) begin
         r_level      <= '0;
         r_round      <= '0;
         r_mode       <= MODE_PLAIN;
         r_player     <= '0;
         r_streak_cap <= '0;
         r_bonus      <= '0;
         r_total      <= '{default: '0};
         r_streak     <= '{default: '0};
         r_high       <= '0;
         r_valid      <= 1'b0;
         r_drop       <= 1'b0;
         r_sat        <= 1'b0;
      end else begin
         r_valid  <= 1'b0;
         r_drop   <= w_drop_nxt;
         r_total  <= w_total_nxt;
         r_streak <= w_streak_nxt;
         if (CLEAR) begin
            r_sat <= 1'b0;
         end else begin
            if (w_accept) begin
               r_level      <= REG_SetupLEVEL;
               r_round      <= ROUND;
               r_mode       <= mode_e'(REG_SetupMAPA);
               r_player     <= PLAYER;
               r_streak_cap <= w_cap_streak;
            end
            if (r_state == CALC) r_bonus <= w_bonus_c;
            if (w_acc) begin
               r_valid <= 1'b1;
               if (w_clip) r_sat <= 1'b1;
               if (w_total_new > r_high) r_high <= w_total_new;
            end
         end
      end
   end

   assign POINTS      = w_player_ok ? r_total[PLAYER] : '0;
   assign HIGH_SCORE  = r_high;
   assign SCORE_VALID = r_valid;
   assign BUSY        = (r_state != IDLE);
   assign DROP        = r_drop;
   assign SAT         = r_sat;

endmodule

// File: tb/tb_score_accum.sv
// Self-checking bench for score_accum at default parameters.
module tb_score_accum;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       round_ok, round_miss, clear;
   logic [3:0] round_len;
   logic [1:0] level, mapa;
   logic [0:0] player;
   logic [7:0] points, high_score;
   logic       score_valid, busy, drop, sat;

   int nvec = 0;
   int nerr = 0;

   // Reference state: per-channel totals and streaks, best score, sticky clip
   int tot [2];
   int stk [2];
   int high;
   int sat_m;

   always #5 clk = ~clk;

   score_accum dut (
      .CLOCK          (clk),
      .RESET          (rst_n),
      .ROUND_OK       (round_ok),
      .ROUND_MISS     (round_miss),
      .ROUND          (round_len),
      .REG_SetupLEVEL (level),
      .REG_SetupMAPA  (mapa),
      .PLAYER         (player),
      .CLEAR          (clear),
      .POINTS         (points),
      .HIGH_SCORE     (high_score),
      .SCORE_VALID    (score_valid),
      .BUSY           (busy),
      .DROP           (drop),
      .SAT            (sat)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int q = 0; q < 2; q++) begin
         tot[q] = 0;
         stk[q] = 0;
      end
      sat_m = 0;
   endtask

   task automatic check_totals(input string tag);
      for (int q = 0; q < 2; q++) begin
         player = 1'(q);
         #1;
         check(tag, 32'(points), tot[q]);
      end
   endtask

   // One accepted round; optional miss in CALC or ACC, optional rejected OK in CALC
   task automatic do_op(input int p, input int l, input int r, input int m,
                        input int miss_p, input bit miss_acc, input bit extra);
      int bonus;
      @(negedge clk);
      round_ok = 1'b1; player = 1'(p); level = 2'(l); round_len = 4'(r); mapa = 2'(m);
      @(negedge clk);
      round_ok = 1'b0;
      check("busy_calc", 32'(busy), 1);
      check("valid_calc", 32'(score_valid), 0);
      if (miss_p >= 0 && !miss_acc) begin round_miss = 1'b1; player = 1'(miss_p); end
      if (extra) round_ok = 1'b1;
      @(negedge clk);
      round_ok = 1'b0; round_miss = 1'b0;
      check("busy_acc", 32'(busy), 1);
      check("valid_acc", 32'(score_valid), 0);
      check("drop_busy", 32'(drop), 32'(extra));
      if (miss_p >= 0 && miss_acc) begin round_miss = 1'b1; player = 1'(miss_p); end
      @(negedge clk);
      round_miss = 1'b0; player = 1'(p);
      // bonus uses the streak seen at acceptance
      case (m)
         0:       bonus = l * r;
         1:       bonus = l * r + stk[p];
         2:       bonus = 2 * l * r;
         default: bonus = l * r + l;
      endcase
      if (miss_p >= 0) stk[miss_p] = 0;
      tot[p] = tot[p] + bonus;
      if (tot[p] > 255) begin tot[p] = 255; sat_m = 1; end
      if (stk[p] < 15) stk[p] = stk[p] + 1;
      if (tot[p] > high) high = tot[p];
      #1;
      check("valid_pulse", 32'(score_valid), 1);
      check("busy_done", 32'(busy), 0);
      check("drop_done", 32'(drop), 0);
      check("points", 32'(points), tot[p]);
      check("high", 32'(high_score), high);
      check("sat", 32'(sat), sat_m);
      check_totals("points_all");
      @(negedge clk);
      check("valid_once", 32'(score_valid), 0);
      player = 1'(p);
   endtask

   task automatic do_clear();
      @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      model_reset();
      #1;
      check("clr_sat", 32'(sat), 0);
      check("clr_busy", 32'(busy), 0);
      check_totals("clr_points");
   endtask

   initial begin
      rst_n = 1'b0; round_ok = 1'b0; round_miss = 1'b0; clear = 1'b0;
      round_len = '0; level = '0; mapa = '0; player = '0;
      model_reset();
      high = 0;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_points", 32'(points), 0);
      check("rst_high", 32'(high_score), 0);
      check("rst_valid", 32'(score_valid), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_drop", 32'(drop), 0);
      check("rst_sat", 32'(sat), 0);
      rst_n = 1'b1;

      // Basic plain-mode round
      do_op(0, 3, 15, 0, -1, 1'b0, 1'b0);
      check("r19_points", 32'(points), 45);
      check("r19_high", 32'(high_score), 45);

      // Streak mode on player 1, then a miss resets the streak
      do_op(1, 1, 2, 1, -1, 1'b0, 1'b0);
      check("r20_t1", 32'(points), 2);
      do_op(1, 1, 2, 1, -1, 1'b0, 1'b0);
      check("r20_t2", 32'(points), 5);
      do_op(1, 1, 2, 1, -1, 1'b0, 1'b0);
      check("r20_t3", 32'(points), 9);
      @(negedge clk); round_miss = 1'b1; player = 1'b1;
      @(negedge clk); round_miss = 1'b0;
      stk[1] = 0;
      do_op(1, 1, 2, 1, -1, 1'b0, 1'b0);
      check("r20_t4", 32'(points), 11);

      // Saturation: bring player 0 to 240, then add 90
      do_clear();
      for (int k = 0; k < 5; k++) do_op(0, 3, 15, 0, -1, 1'b0, 1'b0);
      do_op(0, 1, 15, 0, -1, 1'b0, 1'b0);
      check("r21_240", 32'(points), 240);
      do_op(0, 3, 15, 2, -1, 1'b0, 1'b0);
      check("r21_points", 32'(points), 255);
      check("r21_sat", 32'(sat), 1);
      check("r21_high", 32'(high_score), 255);

      // Zero product still completes
      do_clear();
      do_op(0, 0, 9, 0, -1, 1'b0, 1'b0);
      do_op(1, 2, 0, 2, -1, 1'b0, 1'b0);

      // Second ROUND_OK while busy is dropped
      do_op(1, 2, 3, 0, -1, 1'b0, 1'b1);
      check("r22_single", 32'(points), 6);

      // CLEAR in CALC aborts the op; HIGH_SCORE survives
      @(negedge clk);
      round_ok = 1'b1; player = 1'b0; level = 2'd3; round_len = 4'd7; mapa = 2'd0;
      @(negedge clk);
      round_ok = 1'b0; clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      model_reset();
      #1;
      check("r23_busy", 32'(busy), 0);
      check("r23_valid", 32'(score_valid), 0);
      check("r23_high", 32'(high_score), 255);
      check_totals("r23_points");
      @(negedge clk);
      check("r23_valid2", 32'(score_valid), 0);

      // Randomized rounds with misses, drops and clears against the model
      for (int n = 0; n < 60; n++) begin
         int mp;
         if ($urandom_range(0, 9) == 0) do_clear();
         mp = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 1)) : -1;
         do_op(int'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
               mp, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
      end

      // Reset during ACC clears everything immediately
      do_op(0, 3, 15, 2, -1, 1'b0, 1'b0);
      @(negedge clk);
      round_ok = 1'b1; player = 1'b0; level = 2'd2; round_len = 4'd5; mapa = 2'd0;
      @(negedge clk);
      round_ok = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("r24_points", 32'(points), 0);
      check("r24_high", 32'(high_score), 0);
      check("r24_valid", 32'(score_valid), 0);
      check("r24_busy", 32'(busy), 0);
      check("r24_drop", 32'(drop), 0);
      check("r24_sat", 32'(sat), 0);
      @(negedge clk);
      check("r24_valid2", 32'(score_valid), 0);
      rst_n = 1'b1;
      model_reset();
      high = 0;
      do_op(0, 3, 15, 0, -1, 1'b0, 1'b0);
      check("r24_points45", 32'(points), 45);
      check("r24_high45", 32'(high_score), 45);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/score_accum.md
SCORE_ACCUM -- requirements
Module: score_accum

Interface
REQ-001 The block SHALL have parameters: LEVEL_W, default 2, level width; ROUND_W, default 4, round width; POINTS_W, default 8, score width; N_PLAYERS, default 2, number of score channels, minimum 1.
REQ-002 PLAYER_W SHALL be max(1, clog2(N_PLAYERS)).
REQ-003 Ports, in order:
- CLOCK  in  1  single clock; all state changes on its rising edge.
- RESET  in  1  reset, asynchronous, active-low.
- ROUND_OK  in  1  one-cycle pulse: a sequence was completed.
- ROUND_MISS  in  1  one-cycle pulse: a sequence was failed.
- ROUND  in  ROUND_W  sequence length just completed.
- REG_SetupLEVEL  in  LEVEL_W  game level.
- REG_SetupMAPA  in  2  scoring mode.
- PLAYER  in  PLAYER_W  channel addressed by ROUND_OK or ROUND_MISS, and channel shown on POINTS.
- CLEAR  in  1  zero all totals and streaks.
- POINTS  out  POINTS_W  total of channel PLAYER.
- HIGH_SCORE  out  POINTS_W  highest total since reset.
- SCORE_VALID  out  1  one-cycle pulse: an accumulation completed.
- BUSY  out  1  an operation is in flight.
- DROP  out  1  one-cycle pulse: a ROUND_OK was rejected.
- SAT  out  1  sticky flag: a channel total saturated.

Function
REQ-004 FSM states SHALL be IDLE, CALC and ACC; BUSY SHALL be 1 in CALC and ACC.
REQ-005 In IDLE, a ROUND_OK with PLAYER < N_PLAYERS SHALL capture LEVEL, ROUND, MAPA, PLAYER and that channel's streak, then go to CALC.
REQ-006 In CALC, the block SHALL register BONUS, which is BONUS_W = LEVEL_W+ROUND_W+1 bits wide. With P = LEVEL*ROUND, BONUS SHALL be:
- MAPA 0: P.
- MAPA 1: P + streak.
- MAPA 2: 2*P.
- MAPA 3: P + LEVEL.
The block SHALL then go to ACC.
REQ-007 On the ACC edge, the block SHALL:
- set the channel total to min(total+BONUS, 2^POINTS_W-1);
- set SAT if the sum was clipped;
- increment the streak, saturating at 2^ROUND_W-1;
- update HIGH_SCORE if the new total exceeds it;
- pulse SCORE_VALID;
- return to IDLE.
REQ-008 Latency: with ROUND_OK sampled at edge t, totals and SCORE_VALID SHALL update at edge t+2, and a new ROUND_OK SHALL be accepted at edge t+3.
REQ-009 A ROUND_OK sampled while BUSY, or with PLAYER >= N_PLAYERS, SHALL be ignored and SHALL pulse DROP on the next cycle.
REQ-010 ROUND_MISS SHALL zero the addressed channel's streak in any state. An in-flight operation SHALL keep its captured streak, and its ACC increment SHALL apply after the zeroing.
REQ-011 CLEAR SHALL take priority in every state:
- zero all totals and streaks;
- clear SAT;
- abort any in-flight operation to IDLE with no SCORE_VALID;
- ignore a same-cycle ROUND_OK without a DROP pulse.
HIGH_SCORE SHALL be preserved.
REQ-012 ROUND=0 or LEVEL=0 SHALL give P=0; the operation SHALL still complete and pulse SCORE_VALID.
REQ-013 POINTS SHALL be a combinational read of the registered total selected by PLAYER, and SHALL be 0 when PLAYER >= N_PLAYERS.
REQ-014 All arithmetic SHALL be unsigned. Sums SHALL be computed at max(BONUS_W, POINTS_W)+1 bits before saturation.

Reset
REQ-015 While RESET=0, the block SHALL asynchronously force:
- state to IDLE;
- all totals, streaks and HIGH_SCORE to 0;
- POINTS, SCORE_VALID, BUSY, DROP and SAT to 0.
REQ-016 RESET asserted mid-operation SHALL discard the operation with no SCORE_VALID.

Structure
REQ-017 Package score_pkg SHALL hold:
- the MAPA mode encodings (MODE_PLAIN=0, MODE_STREAK=1, MODE_DOUBLE=2, MODE_LEVEL=3);
- the FSM state enumeration;
- the BONUS_W derivation.
REQ-018 The BONUS computation (REQ-006) SHALL be the combinational sub-module score_bonus_calc; totals, streaks and the FSM SHALL stay in score_accum.

Verification (default parameters)
REQ-019 LEVEL=3, ROUND=15, MAPA=0, PLAYER=0, ROUND_OK -> after 3 edges POINTS=45, HIGH_SCORE=45, one SCORE_VALID pulse.
REQ-020 Three ROUND_OK on player 1 with LEVEL=1, ROUND=2, MAPA=1 -> totals 2, 5, 9 (streaks 0, 1, 2); then ROUND_MISS and one more ROUND_OK -> total 11.
REQ-021 Player 0 at 240, LEVEL=3, ROUND=15, MAPA=2 -> POINTS=255, SAT=1, HIGH_SCORE=255.
REQ-022 A second ROUND_OK one cycle after the first -> DROP pulse, BUSY=1, only one accumulation.
REQ-023 CLEAR in CALC -> no SCORE_VALID, all totals 0, HIGH_SCORE unchanged.
REQ-024 RESET=0 during ACC -> all outputs 0 immediately; a ROUND_OK after release behaves as in REQ-019.
